// File: rtl/uart_tx_streamer.sv
// uart_tx_streamer
//   Byte FIFO in front of a memory-mapped UART. After reset the baud divisor
//   is written once; each queued byte is then sent as: write TXDATA, write
//   CTRL with the start word, wait two cycles, poll STATUS until not busy.
//
// Ports
//   i_Clk, i_Rst        clock (rising edge), asynchronous active-low reset
//   i_Valid, i_Data     push strobe and byte; accepted when o_Ready is high
//   o_Ready, o_Level    FIFO not full, FIFO occupancy (0..DEPTH)
//   o_Idle              FIFO empty and sequencer idle
//   o_WEnable/WAddr/WData   registered UART write strobe, address, data
//   o_REnable/RAddr         registered UART read strobe, address
//   i_RData             UART read data, valid the cycle after o_REnable
//   i_Err, o_Err        UART bus error in, sticky error flag out
//
// Build option
//   UART_STREAM_ERR_STOP_EN: any bus error outside INIT parks the sequencer
//   in HALT (no strobes, no pops) until reset.
module uart_tx_streamer #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] BAUD_DIV    = 32'd13021,
    parameter logic [31:0] CTRL_ADDR   = 32'd0,
    parameter logic [31:0] BAUD_ADDR   = 32'd1,
    parameter logic [31:0] TXDATA_ADDR = 32'd2,
    parameter logic [31:0] STAT_ADDR   = 32'd3,
    parameter logic [31:0] CTRL_START  = 32'h5,
    parameter int unsigned BUSY_BIT    = 0
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Valid,
    input  logic [7:0]             i_Data,
    output logic                   o_Ready,
    output logic [$clog2(DEPTH):0] o_Level,
    output logic                   o_Idle,
    output logic                   o_WEnable,
    output logic [31:0]            o_WAddr,
    output logic [31:0]            o_WData,
    output logic                   o_REnable,
    output logic [31:0]            o_RAddr,
    input  logic [31:0]            i_RData,
    input  logic                   i_Err,
    output logic                   o_Err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

`ifdef UART_STREAM_ERR_STOP_EN
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WDATA, S_WCTRL, S_SETTLE, S_POLL, S_PWAIT, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WDATA, S_WCTRL, S_SETTLE, S_POLL, S_PWAIT
    } state_t;
`endif

    state_t        r_State;
    state_t        w_Next;
    logic          r_Settle;

    logic [7:0]    r_Mem [DEPTH];
    logic [AW-1:0] r_WPtr;
    logic [AW-1:0] r_RPtr;
    logic [AW:0]   r_Level;

    logic          r_WEn;
    logic [31:0]   r_WAddr;
    logic [31:0]   r_WData;
    logic          r_REn;
    logic [31:0]   r_RAddr;
    logic          r_Err;

    logic          w_Full;
    logic          w_Empty;
    logic          w_Push;
    logic          w_Pop;
    logic          w_Busy;
    logic          w_WEn;
    logic [31:0]   w_WAddr;
    logic [31:0]   w_WData;
    logic          w_REn;
    logic [31:0]   w_RAddr;
    logic          w_unused_rdata;

    assign w_Full         = (r_Level == FULL_LEVEL);
    assign w_Empty        = (r_Level == '0);
    assign w_Push         = i_Valid && !w_Full;
    assign w_Pop          = (r_State == S_WDATA);
    assign w_Busy         = i_RData[BUSY_BIT];
    assign w_unused_rdata = ^i_RData;

    // ---------------- FIFO ----------------
    always_ff @(posedge i_Clk) begin
        if (w_Push) begin
            r_Mem[r_WPtr] <= i_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_WPtr  <= '0;
            r_RPtr  <= '0;
            r_Level <= '0;
        end else begin
            if (w_Push) begin
                r_WPtr <= r_WPtr + 1'b1;
            end
            if (w_Pop) begin
                r_RPtr <= r_RPtr + 1'b1;
            end
            case ({w_Push, w_Pop})
                2'b10:   r_Level <= r_Level + 1'b1;
                2'b01:   r_Level <= r_Level - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State  <= S_INIT;
            r_Settle <= 1'b0;
        end else begin
            r_State  <= w_Next;
            // Second SETTLE cycle is marked by r_Settle; it returns to 0 on exit.
            r_Settle <= (r_State == S_SETTLE) && !r_Settle;
        end
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            S_INIT:   w_Next = S_IDLE;
            S_IDLE:   if (!w_Empty) w_Next = S_WDATA;
            S_WDATA:  w_Next = S_WCTRL;
            S_WCTRL:  w_Next = S_SETTLE;
            S_SETTLE: if (r_Settle) w_Next = S_POLL;
            S_POLL:   w_Next = S_PWAIT;
            S_PWAIT:  w_Next = w_Busy ? S_POLL : S_IDLE;
`ifdef UART_STREAM_ERR_STOP_EN
            S_HALT:   w_Next = S_HALT;
`endif
            default:  w_Next = S_INIT;
        endcase
`ifdef UART_STREAM_ERR_STOP_EN
        if (i_Err && (r_State != S_INIT)) begin
            w_Next = S_HALT;
        end
`endif
    end

    // Bus registers load the action of the state being entered, so each
    // strobe is visible during its own state. INIT's baud write is the
    // exception: it is loaded on leaving INIT and shows in the first IDLE cycle.
    always_comb begin
        w_WEn   = 1'b0;
        w_WAddr = '0;
        w_WData = '0;
        w_REn   = 1'b0;
        w_RAddr = '0;
        if (r_State == S_INIT) begin
            w_WEn   = 1'b1;
            w_WAddr = BAUD_ADDR;
            w_WData = BAUD_DIV;
        end else begin
            case (w_Next)
                S_WDATA: begin
                    w_WEn   = 1'b1;
                    w_WAddr = TXDATA_ADDR;
                    w_WData = {24'b0, r_Mem[r_RPtr]};
                end
                S_WCTRL: begin
                    w_WEn   = 1'b1;
                    w_WAddr = CTRL_ADDR;
                    w_WData = CTRL_START;
                end
                S_POLL: begin
                    w_REn   = 1'b1;
                    w_RAddr = STAT_ADDR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_WEn   <= 1'b0;
            r_WAddr <= '0;
            r_WData <= '0;
            r_REn   <= 1'b0;
            r_RAddr <= '0;
            r_Err   <= 1'b0;
        end else begin
            r_WEn   <= w_WEn;
            r_WAddr <= w_WAddr;
            r_WData <= w_WData;
            r_REn   <= w_REn;
            r_RAddr <= w_RAddr;
            r_Err   <= r_Err | i_Err;
        end
    end

    assign o_Ready   = !w_Full;
    assign o_Level   = r_Level;
    assign o_Idle    = w_Empty && (r_State == S_IDLE);
    assign o_WEnable = r_WEn;
    assign o_WAddr   = r_WAddr;
    assign o_WData   = r_WData;
    assign o_REnable = r_REn;
    assign o_RAddr   = r_RAddr;
    assign o_Err     = r_Err;

endmodule
